// File: rtl/word_bank.sv
// word_bank: bank of Depth registered words with one addressed read-modify-write
// port (LOAD/SET/CLR/TOG) and two registered read ports with write-through bypass.
module word_bank #(
  parameter int unsigned Width     = 8,
  parameter int unsigned Depth     = 4,
  parameter int unsigned AddrWidth = 2,
  parameter logic [Width-1:0] RST  = {Width{1'b0}},
  parameter logic [Width-1:0] PST  = {Width{1'b1}}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pst,
  input  logic                 we,
  input  logic [1:0]           op,
  input  logic [AddrWidth-1:0] wa,
  input  logic [Width-1:0]     D,
  input  logic [AddrWidth-1:0] ra0,
  input  logic [AddrWidth-1:0] ra1,
  output logic [Width-1:0]     Q0,
  output logic [Width-1:0]     Q1
);

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SET  = 2'b01,
    OP_CLR  = 2'b10,
    OP_TOG  = 2'b11
  } op_e;

  logic [Width-1:0] mem [Depth];

  logic             wa_hit_c;
  logic [Width-1:0] cur_c;
  logic [Width-1:0] wval_c;
  logic             wr_c;
  logic [Width-1:0] rd0_c;
  logic [Width-1:0] rd1_c;

  // Fetch the addressed word; an out-of-range address never matches, so no write.
  always_comb begin
    wa_hit_c = 1'b0;
    cur_c    = RST;
    for (int i = 0; i < int'(Depth); i++) begin
      if (wa == AddrWidth'(i)) begin
        wa_hit_c = 1'b1;
        cur_c    = mem[i];
      end
    end
  end

  // New value of the written word for the selected bit operation.
  always_comb begin
    wval_c = D;
    unique case (op_e'(op))
      OP_LOAD: wval_c = D;
      OP_SET:  wval_c = cur_c | D;
      OP_CLR:  wval_c = cur_c & ~D;
      OP_TOG:  wval_c = cur_c ^ D;
      default: wval_c = D;
    endcase
    wr_c = we & wa_hit_c;
  end

  // Read muxes: out-of-range reads return RST; a same-edge write to the address wins.
  always_comb begin
    rd0_c = RST;
    rd1_c = RST;
    for (int i = 0; i < int'(Depth); i++) begin
      if (ra0 == AddrWidth'(i)) rd0_c = mem[i];
      if (ra1 == AddrWidth'(i)) rd1_c = mem[i];
    end
    if (wr_c && (ra0 == wa)) rd0_c = wval_c;
    if (wr_c && (ra1 == wa)) rd1_c = wval_c;
  end

  // Storage and read registers: rst beats pst beats the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(Depth); i++) mem[i] <= RST;
      Q0 <= RST;
      Q1 <= RST;
    end else if (pst) begin
      for (int i = 0; i < int'(Depth); i++) mem[i] <= PST;
      Q0 <= PST;
      Q1 <= PST;
    end else begin
      for (int i = 0; i < int'(Depth); i++) begin
        if (wr_c && (wa == AddrWidth'(i))) mem[i] <= wval_c;
      end
      Q0 <= rd0_c;
      Q1 <= rd1_c;
    end
  end

endmodule
